mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/data_mem.sv | 51 +++++
 rtl/mem_wb_stage.sv | 116 +++++++++++
 tb/tb_mem_wb_stage.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Brief    : Shared widths, MEM-stage state encoding and helpers for the pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int DATA_W = 8;
    localparam int REG_W  = 3;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } mem_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem.sv
`default_nettype none
// ============================================================================
// Module   : data_mem
// Brief    : Byte-wide data memory, one write port and one read port.
//            MEM_SYNC_READ_EN selects a registered read port (else async read).
// Revision : 1.0 - initial release
// ============================================================================
module data_mem
    import pipe_pkg::*;
#(
    parameter int DMEM_DEPTH = 256
)
(
    input  logic              clk,
    input  logic              we,
    input  logic [DATA_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int c_addr_w = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

    logic [DATA_W-1:0]   r_mem [DMEM_DEPTH];
    logic [c_addr_w-1:0] w_waddr;
    logic [c_addr_w-1:0] w_raddr;

    // Out-of-range addresses fold back into the array
    assign w_waddr = c_addr_w'(32'(waddr) % DMEM_DEPTH);
    assign w_raddr = c_addr_w'(32'(raddr) % DMEM_DEPTH);

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[w_waddr] <= wdata;
        end
    end

`ifdef MEM_SYNC_READ_EN
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        r_rdata <= r_mem[w_raddr];
    end

    assign rdata = r_rdata;
`else
    assign rdata = r_mem[w_raddr];
`endif

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage
// Brief    : MEM/WB pipeline stage with data memory. MEM_SYNC_READ_EN selects
//            a sync-read memory with a one-cycle load stall (default: async).
// Revision : 1.0 - initial release
// ============================================================================
module mem_wb_stage
    import pipe_pkg::*;
#(
    parameter int DMEM_DEPTH = 256
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write_mem_i,
    input  logic              read_mem_i,
    input  logic              write_reg_i,
    input  logic [DATA_W-1:0] aluOut_i,
    input  logic [DATA_W-1:0] data2_i,
    input  logic [REG_W-1:0]  regD_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              write_reg_o,
    output logic [REG_W-1:0]  regD_o,
    output logic [DATA_W-1:0] wbData_o,
    output logic [7:0]        stallCnt_o
);

    logic              w_store;
    logic              w_load;
    logic              w_both;
    logic [DATA_W-1:0] w_rdata;

    assign w_store = write_mem_i && !flush_i;
    assign w_load  = read_mem_i && !write_mem_i && !flush_i;
    assign w_both  = read_mem_i && write_mem_i;

    data_mem #(
        .DMEM_DEPTH (DMEM_DEPTH)
    ) u_data_mem (
        .clk   (clk),
        .we    (w_store),
        .waddr (aluOut_i),
        .wdata (data2_i),
        .raddr (aluOut_i),
        .rdata (w_rdata)
    );

`ifdef MEM_SYNC_READ_EN
    mem_state_t r_state;
    logic [7:0] r_stall_cnt;
    logic       w_stall;

    // Gated by rst_n so the stall drops the instant reset asserts
    assign w_stall = rst_n && (r_state == IDLE) && w_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            write_reg_o <= 1'b0;
            regD_o      <= '0;
            wbData_o    <= '0;
            r_stall_cnt <= 8'd0;
        end else begin
            if (w_stall) begin
                r_stall_cnt <= sat_inc8(r_stall_cnt);
            end
            if (flush_i) begin
                r_state     <= IDLE;
                write_reg_o <= 1'b0;
                regD_o      <= '0;
                wbData_o    <= '0;
            end else if (r_state == LOAD_WAIT) begin
                r_state     <= IDLE;
                write_reg_o <= write_reg_i;
                regD_o      <= regD_i;
                wbData_o    <= w_rdata;
            end else if (w_load) begin
                r_state     <= LOAD_WAIT;
                write_reg_o <= 1'b0;
                regD_o      <= '0;
                wbData_o    <= '0;
            end else begin
                write_reg_o <= write_reg_i && !w_both;
                regD_o      <= regD_i;
                wbData_o    <= aluOut_i;
            end
        end
    end

    assign stall_o    = w_stall;
    assign stallCnt_o = r_stall_cnt;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_reg_o <= 1'b0;
            regD_o      <= '0;
            wbData_o    <= '0;
        end else if (flush_i) begin
            write_reg_o <= 1'b0;
            regD_o      <= '0;
            wbData_o    <= '0;
        end else begin
            write_reg_o <= write_reg_i && !w_both;
            regD_o      <= regD_i;
            wbData_o    <= w_load ? w_rdata : aluOut_i;
        end
    end

    assign stall_o    = 1'b0;
    assign stallCnt_o = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_wb_stage
// Brief    : Scoreboard bench for mem_wb_stage, random and directed traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

    localparam int DEPTH = 256;
`ifdef MEM_SYNC_READ_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       write_mem_i = 1'b0, read_mem_i = 1'b0, write_reg_i = 1'b0, flush_i = 1'b0;
    logic [7:0] aluOut_i = '0, data2_i = '0;
    logic [2:0] regD_i = '0;
    logic       stall_o, write_reg_o;
    logic [2:0] regD_o;
    logic [7:0] wbData_o, stallCnt_o;

    mem_wb_stage #(.DMEM_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .write_mem_i (write_mem_i),
        .read_mem_i  (read_mem_i),
        .write_reg_i (write_reg_i),
        .aluOut_i    (aluOut_i),
        .data2_i     (data2_i),
        .regD_i      (regD_i),
        .flush_i     (flush_i),
        .stall_o     (stall_o),
        .write_reg_o (write_reg_o),
        .regD_o      (regD_o),
        .wbData_o    (wbData_o),
        .stallCnt_o  (stallCnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         chk_data;
        logic       wr;
        logic [2:0] rd;
        logic [7:0] wb;
        logic [7:0] cnt;
    } exp_t;

    exp_t       out_q[$];
    bit         stall_q[$];
    logic [7:0] mem_m [DEPTH];
    int         cnt_m = 0;
    int         n_chk = 0;
    int         n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] cnt8();
        return SYNC ? 8'(cnt_m) : 8'd0;
    endfunction

    task automatic push(input bit stall, input bit cd, input logic wr,
                        input logic [2:0] rd, input logic [7:0] wb);
        exp_t e;
        if (stall && cnt_m < 255) cnt_m++;
        e.chk_data = cd; e.wr = wr; e.rd = rd; e.wb = wb; e.cnt = cnt8();
        stall_q.push_back(stall);
        out_q.push_back(e);
    endtask

    task automatic drive(input bit rd, input bit wr, input bit wri, input logic [7:0] alu,
                         input logic [7:0] d2, input logic [2:0] ri, input bit fl);
        @(negedge clk);
        read_mem_i = rd; write_mem_i = wr; write_reg_i = wri;
        aluOut_i = alu; data2_i = d2; regD_i = ri; flush_i = fl;
    endtask

    // One instruction; a sync-read load is held for two cycles, optionally flushed in the second
    task automatic instr(input bit rd, input bit wr, input bit wri, input logic [7:0] alu,
                         input logic [7:0] d2, input logic [2:0] ri, input bit fl, input bit fl2);
        int  a = int'(alu) % DEPTH;
        bit  is_load = rd && !wr && !fl;
        if (SYNC && is_load) begin
            drive(rd, wr, wri, alu, d2, ri, 1'b0);
            push(1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
            drive(rd, wr, wri, alu, d2, ri, fl2);
            if (fl2) push(1'b0, 1'b1, 1'b0, 3'd0, 8'd0);
            else     push(1'b0, 1'b1, wri, ri, mem_m[a]);
        end else begin
            drive(rd, wr, wri, alu, d2, ri, fl);
            if (fl)           push(1'b0, 1'b1, 1'b0, 3'd0, 8'd0);
            else if (is_load) push(1'b0, 1'b1, wri, ri, mem_m[a]);
            else begin
                if (wr) mem_m[a] = d2;
                push(1'b0, 1'b1, wri && !rd, ri, alu);
            end
        end
    endtask

    initial begin : mon_stall
        bit e;
        forever begin
            @(negedge clk); #1;
            if (stall_q.size() > 0) begin
                e = stall_q.pop_front();
                chk("stall_o", 32'(stall_o), 32'(e));
            end
        end
    end

    initial begin : mon_out
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (out_q.size() > 0) begin
                e = out_q.pop_front();
                chk("write_reg_o", 32'(write_reg_o), 32'(e.wr));
                chk("stallCnt_o", 32'(stallCnt_o), 32'(e.cnt));
                if (e.chk_data) begin
                    chk("regD_o", 32'(regD_o), 32'(e.rd));
                    chk("wbData_o", 32'(wbData_o), 32'(e.wb));
                end
            end
        end
    end

    initial begin : stim
        #2 rst_n = 1'b0;
        #5;
        chk("rst_write_reg", 32'(write_reg_o), 0);
        chk("rst_regD", 32'(regD_o), 0);
        chk("rst_wbData", 32'(wbData_o), 0);
        chk("rst_stallCnt", 32'(stallCnt_o), 0);
        chk("rst_stall", 32'(stall_o), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int a = 0; a < DEPTH; a++)
            instr(1'b0, 1'b1, 1'($urandom), 8'(a), 8'($urandom), 3'($urandom), 1'b0, 1'b0);

        // Store then dependent load
        instr(1'b0, 1'b1, 1'b0, 8'h10, 8'hA5, 3'd0, 1'b0, 1'b0);
        instr(1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 3'd3, 1'b0, 1'b0);
        // ALU pass-through
        instr(1'b0, 1'b0, 1'b1, 8'h3C, 8'h00, 3'd5, 1'b0, 1'b0);
        // Flush during load wait, flushed store ignored, confirmed by load
        instr(1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 3'd2, 1'b0, 1'b1);
        instr(1'b0, 1'b1, 1'b1, 8'h10, 8'h11, 3'd4, 1'b1, 1'b0);
        instr(1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 3'd6, 1'b0, 1'b0);
        // Simultaneous read and write
        instr(1'b1, 1'b1, 1'b1, 8'h20, 8'h77, 3'd1, 1'b0, 1'b0);
        instr(1'b1, 1'b0, 1'b1, 8'h20, 8'h00, 3'd7, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            int op = int'($urandom_range(0, 5));
            bit r  = (op <= 1) || (op == 4) || (op == 5 && 1'($urandom));
            bit w  = (op == 2) || (op == 4) || (op == 5 && 1'($urandom));
            instr(r, w, 1'($urandom), 8'($urandom), 8'($urandom), 3'($urandom),
                  op == 5, $urandom_range(0, 7) == 0);
        end

        for (int i = 0; i < 300; i++)
            instr(1'b1, 1'b0, 1'b1, 8'($urandom), 8'h00, 3'($urandom), 1'b0, 1'b0);

        // Reset asserted while a load is outstanding
        drive(1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 3'd3, 1'b0);
        if (SYNC) push(1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
        else      push(1'b0, 1'b1, 1'b1, 3'd3, mem_m[16]);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_write_reg", 32'(write_reg_o), 0);
        chk("async_rst_regD", 32'(regD_o), 0);
        chk("async_rst_wbData", 32'(wbData_o), 0);
        chk("async_rst_stallCnt", 32'(stallCnt_o), 0);
        chk("async_rst_stall", 32'(stall_o), 0);
        @(negedge clk);
        cnt_m = 0;
        rst_n = 1'b1;

        // Memory survives reset
        instr(1'b1, 1'b0, 1'b1, 8'h20, 8'h00, 3'd2, 1'b0, 1'b0);
        instr(1'b0, 1'b0, 1'b1, 8'h5A, 8'h00, 3'd4, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(out_q.size() + stall_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
